pwm_duty_sequencer: RTL



---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_duty_sequencer_btn_sync_edge.sv | 32 +++
 rtl/pwm_duty_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// +--------------------------------------------------------------------+
// | pwm_pkg : shared types and defaults for the PWM generator/sequencer |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } seq_state_t;

    localparam int PWM_STEPS      = 10;
    localparam int PWM_TICK_SHIFT = 8;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_duty_sequencer_btn_sync_edge.sv
// +--------------------------------------------------------------------+
// | btn_sync_edge : 2-flop synchronizer followed by rising-edge detect  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic edge_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            prev_q <= sync_q[1];
        end
    end

    // Edge is only a decode of flops; the consumer registers it.
    assign edge_o = sync_q[1] & ~prev_q;

endmodule : btn_sync_edge

`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
// +--------------------------------------------------------------------+
// | pwm_duty_sequencer : manual/triangle-sweep step controller for the  |
// | PWM generator's xu/xd inputs.  Rev 1.0                              |
// +--------------------------------------------------------------------+
`default_nettype none

module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int STEPS      = PWM_STEPS,
    parameter int TICK_SHIFT = PWM_TICK_SHIFT,
    parameter int PRESC_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           btn_up,
    input  logic                           btn_dn,
    input  logic                           auto,
    input  logic [2:0]                     rate,
    output logic                           xu,
    output logic                           xd,
    output logic [$clog2(STEPS+1)-1:0]     duty_idx,
    output logic                           sweeping
);

    localparam int               DW    = $clog2(STEPS + 1);
    localparam int               SHW   = $clog2(PRESC_W);
    localparam logic [DW-1:0]    C_MAX = DW'(STEPS);

    logic w_up_edge;
    logic w_dn_edge;

    btn_sync_edge u_sync_up (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_up),
        .edge_o (w_up_edge)
    );

    btn_sync_edge u_sync_dn (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_dn),
        .edge_o (w_dn_edge)
    );

    seq_state_t          state_q, state_d;
    logic [DW-1:0]       duty_q, duty_d;
    logic [PRESC_W-1:0]  cnt_q, cnt_d;
    logic [2:0]          rate_q, rate_d;
    logic                xu_q, xu_d;
    logic                xd_q, xd_d;

    logic [SHW-1:0]      w_shamt;
    logic [PRESC_W-1:0]  w_term;
    logic                w_rate_chg;
    logic                w_tick;

    // Terminal count is 2^(rate+TICK_SHIFT)-1, i.e. a mask of that many ones.
    assign w_shamt    = SHW'(rate) + SHW'(TICK_SHIFT);
    assign w_term     = ~({PRESC_W{1'b1}} << w_shamt);
    assign w_rate_chg = (rate != rate_q);
    assign w_tick     = (cnt_q == w_term) && !w_rate_chg;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        xu_d    = 1'b0;
        xd_d    = 1'b0;

        if (ena) begin
            rate_d = rate;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (auto) begin
                        state_d = (duty_q < C_MAX) ? RAMP_UP : RAMP_DN;
                    end else if (w_up_edge && !w_dn_edge && duty_q < C_MAX) begin
                        xu_d   = 1'b1;
                        duty_d = duty_q + DW'(1);
                    end else if (w_dn_edge && !w_up_edge && duty_q != '0) begin
                        xd_d   = 1'b1;
                        duty_d = duty_q - DW'(1);
                    end
                end
                RAMP_UP: begin
                    if (!auto) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (w_rate_chg) begin
                        cnt_d = '0;
                    end else if (w_tick) begin
                        cnt_d = '0;
                        if (duty_q < C_MAX) begin
                            xu_d   = 1'b1;
                            duty_d = duty_q + DW'(1);
                            if (duty_q + DW'(1) == C_MAX) state_d = RAMP_DN;
                        end else begin
                            state_d = RAMP_DN;
                        end
                    end else begin
                        cnt_d = cnt_q + PRESC_W'(1);
                    end
                end
                RAMP_DN: begin
                    if (!auto) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (w_rate_chg) begin
                        cnt_d = '0;
                    end else if (w_tick) begin
                        cnt_d = '0;
                        if (duty_q != '0) begin
                            xd_d   = 1'b1;
                            duty_d = duty_q - DW'(1);
                            if (duty_q == DW'(1)) state_d = RAMP_UP;
                        end else begin
                            state_d = RAMP_UP;
                        end
                    end else begin
                        cnt_d = cnt_q + PRESC_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            cnt_q   <= '0;
            rate_q  <= 3'd0;
            xu_q    <= 1'b0;
            xd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            xu_q    <= xu_d;
            xd_q    <= xd_d;
        end
    end

    assign xu       = xu_q;
    assign xd       = xd_q;
    assign duty_idx = duty_q;
    assign sweeping = (state_q == RAMP_UP) || (state_q == RAMP_DN);

endmodule : pwm_duty_sequencer

`default_nettype wire
